// File: rtl/seq_match_sched.sv
// rtl/seq_match_sched.sv - round-robin scheduler sharing one pa2_fsm sequence-match engine
//
// Grants the engine to one of N requesters at a time (round-robin from ptr),
// streams the owner's req_seq words into the engine, counts the engine's hit
// pulses while draining, and reports the count back with a one-cycle done.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-low reset
//   req[N]            per-requester request, sampled in IDLE
//   req_len[4N]       per-requester sequence length, sampled at grant
//   req_num[4N]       per-requester target number, sampled at grant
//   req_seq[4N]       per-requester current sequence word, passed through in SEND
//   grant[N]          one-hot owner during SEND and DRAIN
//   seq_rdy           owner advances req_seq on each cycle this is high
//   done[N]           one-hot single-cycle completion pulse
//   result[4]         hit count for the completing requester, valid with done
//   busy              high outside IDLE
//   fsm_valid/num/seq to engine; fsm_hit from engine
module seq_match_sched #(
   parameter int N = 4
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [4*N-1:0] req_len,
   input  logic [4*N-1:0] req_num,
   input  logic [4*N-1:0] req_seq,
   output logic [N-1:0]   grant,
   output logic           seq_rdy,
   output logic [N-1:0]   done,
   output logic [3:0]     result,
   output logic           busy,
   output logic           fsm_valid,
   output logic [3:0]     fsm_num,
   output logic [3:0]     fsm_seq,
   input  logic           fsm_hit
);
   localparam int OW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = OW + 1;
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;

   state_t        state;
   logic [OW-1:0] owner;
   logic [OW-1:0] ptr;
   logic [3:0]    rem;
   logic [3:0]    hits;
   logic [4:0]    dcyc;
   logic [3:0]    num_q;

   logic          pick_found;
   logic [OW-1:0] pick;
   logic [SW-1:0] sum;
   logic [OW-1:0] cand;
   logic [3:0]    pick_len;
   logic [3:0]    hits_nxt;
   logic [OW-1:0] owner_inc;

   // First requester at or after ptr, wrapping modulo N (N need not be a power of two).
   always_comb begin
      pick_found = 1'b0;
      pick       = '0;
      sum        = '0;
      cand       = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + SW'(k);
         if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
         end
         cand = sum[OW-1:0];
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick       = cand;
         end
      end
   end

   assign pick_len  = req_len[{pick, 2'b00} +: 4];
   assign hits_nxt  = (fsm_hit && hits != 4'hF) ? hits + 4'd1 : hits;
   assign owner_inc = (owner == OW'(N - 1)) ? '0 : owner + OW'(1);

   assign fsm_num = num_q;
   assign fsm_seq = (state == SEND) ? req_seq[{owner, 2'b00} +: 4] : 4'd0;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         owner     <= '0;
         ptr       <= '0;
         rem       <= 4'd0;
         hits      <= 4'd0;
         dcyc      <= 5'd0;
         num_q     <= 4'd0;
         grant     <= '0;
         done      <= '0;
         result    <= 4'd0;
         busy      <= 1'b0;
         seq_rdy   <= 1'b0;
         fsm_valid <= 1'b0;
      end else begin
         done <= '0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  owner <= pick;
                  rem   <= pick_len;
                  num_q <= req_num[{pick, 2'b00} +: 4];
                  hits  <= 4'd0;
                  dcyc  <= 5'd0;
                  busy  <= 1'b1;
                  if (pick_len != 4'd0) begin
                     state     <= SEND;
                     grant     <= ONE << pick;
                     seq_rdy   <= 1'b1;
                     fsm_valid <= 1'b1;
                  end else begin
                     // Zero-length job never touches the engine.
                     state  <= DONE;
                     done   <= ONE << pick;
                     result <= 4'd0;
                  end
               end
            end
            SEND: begin
               rem <= rem - 4'd1;
               if (rem == 4'd1) begin
                  state     <= DRAIN;
                  seq_rdy   <= 1'b0;
                  fsm_valid <= 1'b0;
               end
            end
            DRAIN: begin
               dcyc <= dcyc + 5'd1;
               hits <= hits_nxt;
               // Give the engine at least two cycles to start reporting, and
               // bound the drain at 18 cycles in case hit sticks high.
               if ((!fsm_hit && dcyc != 5'd0) || dcyc == 5'd17) begin
                  state  <= DONE;
                  grant  <= '0;
                  done   <= ONE << owner;
                  result <= hits_nxt;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy   <= 1'b0;
               result <= 4'd0;
               ptr    <= owner_inc;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_match_sched.sv
// tb/tb_seq_match_sched.sv - scoreboard bench for seq_match_sched with a behavioural engine
module tb_seq_match_sched;
   localparam int N = 4;

   typedef struct {
      int owner;
      int res;
      int cyc;
      int nvalid;
      int ngrant;
   } exp_t;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req = '0;
   logic [4*N-1:0] req_len = '0;
   logic [4*N-1:0] req_num = '0;
   logic [4*N-1:0] req_seq;
   logic [N-1:0]   grant;
   logic [N-1:0]   done;
   logic           seq_rdy, busy, fsm_valid, fsm_hit;
   logic [3:0]     result, fsm_num, fsm_seq;

   // Per-requester word streams; idx is the consumer position, wp the writer position.
   logic [3:0] words [N][256];
   logic [7:0] idx [N];
   logic [7:0] wp [N];

   int   cnt = 0;
   logic stuck = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sbq[$];
   int   ptr_m = 0;
   int   vcnt = 0;
   int   gcnt = 0;

   seq_match_sched #(.N(N)) dut (
      .clock(clock), .reset(reset), .req(req), .req_len(req_len), .req_num(req_num),
      .req_seq(req_seq), .grant(grant), .seq_rdy(seq_rdy), .done(done), .result(result),
      .busy(busy), .fsm_valid(fsm_valid), .fsm_num(fsm_num), .fsm_seq(fsm_seq),
      .fsm_hit(fsm_hit)
   );

   always #5 clock = ~clock;

   // Engine model: remembers how many streamed words equalled num, then reports
   // them as contiguous hit cycles once valid drops. stuck forces hit high.
   assign fsm_hit = stuck || (!fsm_valid && cnt != 0);

   always_comb begin
      req_seq = '0;
      for (int i = 0; i < N; i++) req_seq[4*i +: 4] = words[i][idx[i]];
   end

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (!reset) begin
         cnt <= 0;
         for (int i = 0; i < N; i++) idx[i] <= 8'd0;
      end else begin
         if (fsm_valid) cnt <= cnt + ((fsm_seq == fsm_num) ? 1 : 0);
         else if (fsm_hit && cnt != 0) cnt <= cnt - 1;
         for (int i = 0; i < N; i++)
            if (seq_rdy && grant[i]) idx[i] <= idx[i] + 8'd1;
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] m, input int p);
      for (int k = 0; k < N; k++) begin
         if (m[(p + k) % N]) return (p + k) % N;
      end
      return 0;
   endfunction

   function automatic int drain_len(input int m, input bit stk);
      if (stk) return 18;
      return ((m < 1) ? 1 : m) + 1;
   endfunction

   function automatic logic [3:0] gen(input int mode, input logic [3:0] num);
      case (mode)
         1:       return num;
         2:       return ~num;
         3:       return ($urandom_range(0, 1) == 1) ? num : 4'($urandom);
         default: return 4'($urandom);
      endcase
   endfunction

   // Monitor: pops one expectation per done pulse; also checks per-cycle invariants.
   always @(negedge clock) begin
      exp_t e;
      int   o;
      if (!reset) begin
         vcnt = 0;
         gcnt = 0;
      end else begin
         chk("grant_onehot", int'((grant & (grant - 1'b1)) != 0), 0);
         if (!seq_rdy) chk("fsm_seq_outside_send", int'(fsm_seq), 0);
         if (fsm_valid) vcnt++;
         if (grant != 0) begin
            gcnt++;
            if (sbq.size() > 0) chk("grant_owner", int'(grant), 1 << sbq[0].owner);
         end
         if (fsm_valid && sbq.size() > 0) begin
            o = sbq[0].owner;
            chk("fsm_seq", int'(fsm_seq), int'(words[o][idx[o]]));
         end
         if (done != 0) begin
            if (sbq.size() == 0) begin
               chk("unexpected_done", int'(done), 0);
            end else begin
               e = sbq.pop_front();
               chk("done_onehot", int'(done), 1 << e.owner);
               chk("result", int'(result), e.res);
               chk("done_cycle", cyc, e.cyc);
               chk("valid_cycles", vcnt, e.nvalid);
               chk("grant_cycles", gcnt, e.ngrant);
            end
            vcnt = 0;
            gcnt = 0;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clock);
         #1;
         n++;
      end while ((busy || sbq.size() != 0) && n < 400);
      if (n >= 400) chk("idle_timeout", 0, 1);
      stuck = 1'b0;
   endtask

   task automatic issue(input logic [3:0] mask, input int len, input logic [3:0] num,
                        input int mode, input bit stk, input bit push);
      int         c, o, m, d, dl;
      logic [3:0] w;
      exp_t       e;
      wait_idle();
      c = cyc;
      o = rr_pick(mask, ptr_m);
      m = 0;
      for (int j = 0; j < len; j++) begin
         w = gen(mode, num);
         words[o][wp[o]] = w;
         wp[o] = wp[o] + 8'd1;
         if (w == num) m++;
      end
      for (int i = 0; i < N; i++) begin
         req_len[4*i +: 4] = 4'($urandom);
         req_num[4*i +: 4] = 4'($urandom);
      end
      req_len[4*o +: 4] = 4'(len);
      req_num[4*o +: 4] = num;
      stuck = stk;
      req = mask;
      if (push) begin
         dl       = drain_len(m, stk);
         d        = (len == 0) ? 1 : len + dl + 1;
         e.owner  = o;
         e.res    = (len == 0) ? 0 : (stk ? 15 : m);
         e.cyc    = c + d;
         e.nvalid = len;
         e.ngrant = (len == 0) ? 0 : len + dl;
         sbq.push_back(e);
         ptr_m = (o + 1) % N;
      end
      @(negedge clock);
      #1;
      req = '0;
   endtask

   // All requesters held high: five back-to-back jobs of length 3.
   task automatic rr_burst();
      int         c, o, m, dl, dlast, n;
      logic [3:0] nm [N];
      logic [3:0] w;
      exp_t       e;
      wait_idle();
      c = cyc;
      dlast = c;
      for (int i = 0; i < N; i++) begin
         nm[i] = 4'($urandom);
         req_len[4*i +: 4] = 4'd3;
         req_num[4*i +: 4] = nm[i];
      end
      for (int k = 0; k < 5; k++) begin
         o = rr_pick(4'hF, ptr_m);
         m = 0;
         for (int j = 0; j < 3; j++) begin
            w = ($urandom_range(0, 1) == 1) ? nm[o] : 4'($urandom);
            words[o][wp[o]] = w;
            wp[o] = wp[o] + 8'd1;
            if (w == nm[o]) m++;
         end
         dl       = drain_len(m, 1'b0);
         dlast    = c + 3 + dl + 1;
         e.owner  = o;
         e.res    = m;
         e.cyc    = dlast;
         e.nvalid = 3;
         e.ngrant = 3 + dl;
         sbq.push_back(e);
         ptr_m = (o + 1) % N;
         c = dlast + 1;
      end
      req = 4'hF;
      n = 0;
      while (cyc < dlast && n < 400) begin
         @(negedge clock);
         #1;
         n++;
      end
      if (cyc < dlast) chk("rr_timeout", cyc, dlast);
      req = '0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         wp[i] = 8'd0;
         for (int k = 0; k < 256; k++) words[i][k] = 4'd0;
      end
      reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_grant", int'(grant), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_seq_rdy", int'(seq_rdy), 0);
      chk("rst_fsm_valid", int'(fsm_valid), 0);
      chk("rst_fsm_seq", int'(fsm_seq), 0);
      chk("rst_fsm_num", int'(fsm_num), 0);
      #1;
      reset = 1'b1;

      rr_burst();
      issue(4'b0001, 10, 4'd5, 1, 1'b0, 1'b1);
      issue(4'b0001, 10, 4'd5, 2, 1'b0, 1'b1);
      issue(4'b0010, 1, 4'd9, 1, 1'b0, 1'b1);
      issue(4'b0010, 1, 4'd9, 2, 1'b0, 1'b1);
      issue(4'b0100, 0, 4'd6, 0, 1'b0, 1'b1);
      issue(4'b1000, 15, 4'd3, 1, 1'b0, 1'b1);
      issue(4'b0001, 15, 4'd7, 0, 1'b1, 1'b1);
      issue(4'b0010, 4, 4'd2, 3, 1'b1, 1'b1);

      for (int r = 0; r < 25; r++) begin
         issue(4'($urandom_range(1, 15)), $urandom_range(0, 15), 4'($urandom),
               $urandom_range(0, 3), ($urandom_range(0, 9) == 0), 1'b1);
      end

      // Abort job 3 mid-SEND, then confirm arbitration restarts from ptr 0.
      issue(4'b0001, 5, 4'd1, 3, 1'b0, 1'b1);
      issue(4'b0010, 5, 4'd1, 3, 1'b0, 1'b1);
      issue(4'b0100, 8, 4'd1, 1, 1'b0, 1'b0);
      repeat (3) @(negedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("abort_fsm_valid", int'(fsm_valid), 0);
      chk("abort_grant", int'(grant), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      #1;
      reset = 1'b1;
      ptr_m = 0;
      stuck = 1'b0;
      for (int i = 0; i < N; i++) wp[i] = 8'd0;
      issue(4'b1010, 4, 4'd8, 3, 1'b0, 1'b1);
      issue(4'b1010, 2, 4'd8, 1, 1'b0, 1'b1);

      wait_idle();
      repeat (3) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
